// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Command encoding and pointer-width helper.
package pc_pkg;

    localparam logic [2:0] CMD_HOLD = 3'd0;
    localparam logic [2:0] CMD_SEQ  = 3'd1;
    localparam logic [2:0] CMD_JUMP = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_RET  = 3'd4;
    localparam logic [2:0] CMD_SWAP = 3'd5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Push, pop and replace are mutually exclusive per cycle.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, ptr_inc;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign ptr_inc = ptr_q + PW'(1);
    assign top     = mem_q[ptr_q];
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);

    // ptr_q indexes the top entry; the slot above it is the oldest once full
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        unique case (1'b1)
            push: begin
                ptr_d          = ptr_inc;
                mem_d[ptr_inc] = din;
                if (!full) cnt_d = cnt_q + CW'(1);
            end
            pop: begin
                if (!empty) begin
                    ptr_d = ptr_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end
            replace: mem_d[ptr_q] = din;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with stall, jump, call and return.
// Calls and returns go through a circular return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             STALL,
    input  logic             W_PC,
    input  logic             CALL,
    input  logic             RET,
    input  logic [WIDTH-1:0] TARGET,
    output logic [WIDTH-1:0] PC_OUT,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL,
    output logic             RAS_ERR
);

    logic [2:0]       cmd;
    logic [WIDTH-1:0] pc_q, pc_d, pc_plus;
    logic             err_q, err_d;
    logic             push, pop, repl;
    logic [WIDTH-1:0] ras_top;
    logic             ras_full, ras_empty;

    assign pc_plus = pc_q + WIDTH'(STEP);

    always_comb begin
        cmd = CMD_SEQ;
        priority case (1'b1)
            STALL:       cmd = CMD_HOLD;
            CALL && RET: cmd = CMD_SWAP;
            RET:         cmd = CMD_RET;
            CALL:        cmd = CMD_CALL;
            W_PC:        cmd = CMD_JUMP;
            default:     cmd = CMD_SEQ;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        err_d = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        repl  = 1'b0;
        unique case (cmd)
            CMD_HOLD: ;
            CMD_SWAP: begin
                pc_d = TARGET;
                // an empty stack has no top to replace, so push instead
                if (ras_empty) push = 1'b1;
                else           repl = 1'b1;
            end
            CMD_RET: begin
                if (ras_empty) begin
                    pc_d  = pc_plus;
                    err_d = 1'b1;
                end else begin
                    pc_d = ras_top;
                    pop  = 1'b1;
                end
            end
            CMD_CALL: begin
                pc_d  = TARGET;
                push  = 1'b1;
                err_d = ras_full;
            end
            CMD_JUMP: pc_d = TARGET;
            default:  pc_d = pc_plus;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= RESET_VECTOR;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push),
        .pop     (pop),
        .replace (repl),
        .din     (pc_plus),
        .top     (ras_top),
        .full    (ras_full),
        .empty   (ras_empty)
    );

    assign PC_OUT    = pc_q;
    assign RAS_EMPTY = ras_empty;
    assign RAS_FULL  = ras_full;
    assign RAS_ERR   = err_q;

endmodule
